// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pkg
// Brief    : Shared types and constants for the instruction-fetch datapath.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INST_W           = 32;
    localparam int          PC_INC           = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Pointer-based circular prefetch buffer with flush, push, pop, count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             c_ptr_w = $clog2(DEPTH);
    localparam int             c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Flush dominates both push and pop in the same cycle.
    assign w_do_push = push && !flush && (r_count != c_full);
    assign w_do_pop  = pop  && !flush && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_unit
// Brief    : Instruction-fetch stage: PC, req/ack fetch FSM, redirect, prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import datapath_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = INST_W,
    parameter int            DEPTH    = 4,
    parameter int            INC      = PC_INC,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_req,
    output logic [AW-1:0]              mem_addr,
    input  logic                       mem_ack,
    input  logic [DW-1:0]              mem_rdata,
    input  logic                       redirect_en,
    input  logic [AW-1:0]              redirect_pc,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    output logic [DW-1:0]              ir_data,
    output logic [AW-1:0]              ir_pc,
    output logic [AW-1:0]              fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int                 c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
    localparam logic [AW-1:0]      c_inc   = AW'(INC);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [AW-1:0]      r_fetch_pc;
    logic [AW-1:0]      r_drop_addr;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_count_after;
    logic [AW+DW-1:0]   w_head;

    always_comb begin
        w_state_nxt   = r_state;
        w_push        = 1'b0;
        w_pop         = ir_valid && ir_ready && !redirect_en;
        w_count_after = w_count + c_cnt_w'(1) - c_cnt_w'(w_pop);
        case (r_state)
            IDLE: begin
                if (!redirect_en && (w_count < c_full)) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // An un-acked request cannot be withdrawn, so a redirect must drain it in DROP.
                if (redirect_en) begin
                    w_state_nxt = mem_ack ? REQ : DROP;
                end else if (mem_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = (w_count_after < c_full) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_en) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + c_inc;
            end
            if ((r_state == REQ) && (w_state_nxt == DROP)) begin
                r_drop_addr <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_en),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({r_fetch_pc, mem_rdata}),
        .dout  (w_head),
        .count (w_count)
    );

    assign mem_req     = (r_state == REQ) || (r_state == DROP);
    assign mem_addr    = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
    assign fetch_pc    = r_fetch_pc;
    assign queue_count = w_count;
    assign ir_valid    = (w_count != '0);
    assign ir_pc       = w_head[AW+DW-1:DW];
    assign ir_data     = w_head[DW-1:0];

endmodule
`default_nettype wire
